// File: rtl/bbox_accumulator_pkg.sv
// rtl/bbox_accumulator_pkg.sv - shared types, field offsets and state encodings for the bbox accumulator
package bbox_accumulator_pkg;

    // Accumulator FSM states
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    // Queue entry is {label, x, y} with y in the LSBs
    localparam int Y_LSB = 0;

    function automatic int x_lsb(input int coord_width);
        return coord_width;
    endfunction

    function automatic int label_lsb(input int coord_width);
        return 2 * coord_width;
    endfunction

    function automatic int entry_width(input int label_width, input int coord_width);
        return label_width + 2 * coord_width;
    endfunction

    // Box word is {xmin, xmax, ymin, ymax} with ymax in the LSBs
    localparam int BOX_YMAX_LSB = 0;

    function automatic int box_ymin_lsb(input int coord_width);
        return coord_width;
    endfunction

    function automatic int box_xmax_lsb(input int coord_width);
        return 2 * coord_width;
    endfunction

    function automatic int box_xmin_lsb(input int coord_width);
        return 3 * coord_width;
    endfunction

endpackage

// File: rtl/bbox_accumulator_ram.sv
// rtl/bbox_accumulator_ram.sv - simple dual-port RAM with registered read, old data on collision
module bbox_accumulator_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 40
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // Write port and registered read port; a same-address read returns the pre-write word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/bbox_accumulator.sv
// rtl/bbox_accumulator.sv - per-label bounding box accumulator fed from the pixel-entry queue
module bbox_accumulator
    import bbox_accumulator_pkg::*;
#(
    parameter int LABEL_WIDTH = 8,
    parameter int COORD_WIDTH = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 q_empty,
    input  logic [LABEL_WIDTH+2*COORD_WIDTH-1:0] q_data,
    output logic                                 q_dequeue,
    input  logic                                 rd_en,
    input  logic [LABEL_WIDTH-1:0]               rd_label,
    output logic                                 rd_valid,
    output logic                                 rd_hit,
    output logic [4*COORD_WIDTH-1:0]             rd_box,
    output logic [LABEL_WIDTH:0]                 num_objects,
    output logic                                 busy
);

    localparam int ENTRY_WIDTH = entry_width(LABEL_WIDTH, COORD_WIDTH);
    localparam int LABEL_LSB   = label_lsb(COORD_WIDTH);
    localparam int X_LSB       = x_lsb(COORD_WIDTH);
    localparam int BOX_WIDTH   = 4 * COORD_WIDTH;
    localparam int DEPTH       = 2 ** LABEL_WIDTH;
    localparam logic [LABEL_WIDTH:0] NUM_MAX = {1'b0, {LABEL_WIDTH{1'b1}}};

    logic [ENTRY_WIDTH-1:0] w_entry;
    logic [LABEL_WIDTH-1:0] w_q_label;
    logic [COORD_WIDTH-1:0] w_q_x;
    logic [COORD_WIDTH-1:0] w_q_y;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_sample;
    logic                   r_q_empty_d;
    logic                   r_deq_d;

    logic [LABEL_WIDTH-1:0] r_label;
    logic [COORD_WIDTH-1:0] r_x;
    logic [COORD_WIDTH-1:0] r_y;

    logic [DEPTH-1:0]       r_valid;
    logic [LABEL_WIDTH:0]   r_num;

    logic [LABEL_WIDTH-1:0] w_ram_raddr;
    logic [BOX_WIDTH-1:0]   w_ram_rdata;
    logic [BOX_WIDTH-1:0]   w_new_box;
    logic [COORD_WIDTH-1:0] w_old_xmin, w_old_xmax, w_old_ymin, w_old_ymax;
    logic [COORD_WIDTH-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic                   w_was_valid;
    logic                   w_write;
    logic                   w_fwd;

    logic                   r_rd_valid;
    logic                   r_rd_hit;
    logic                   r_rd_fwd;
    logic [BOX_WIDTH-1:0]   r_fwd_box;

    assign w_entry   = q_data;
    assign w_q_label = w_entry[LABEL_LSB +: LABEL_WIDTH];
    assign w_q_x     = w_entry[X_LSB +: COORD_WIDTH];
    assign w_q_y     = w_entry[Y_LSB +: COORD_WIDTH];

    // Next state and sample strobe; the queue output is trusted only after two non-empty cycles with no pop last cycle
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!clear && !q_empty && !r_q_empty_d && !r_deq_d && !rd_en) begin
                    w_sample     = 1'b1;
                    w_state_next = S_UPDATE;
                end
            end
            S_UPDATE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (clear) begin
            w_state_next = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One-cycle history of queue emptiness and our own pop strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_empty_d <= 1'b1;
            r_deq_d     <= 1'b0;
        end else begin
            r_q_empty_d <= q_empty;
            r_deq_d     <= w_sample;
        end
    end

    // Hold the popped entry for the UPDATE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_label <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_sample) begin
            r_label <= w_q_label;
            r_x     <= w_q_x;
            r_y     <= w_q_y;
        end
    end

    // Lookup owns the read port whenever requested; sampling is held off in that case
    assign w_ram_raddr = rd_en ? rd_label : w_q_label;

    bbox_accumulator_ram #(
        .ADDR_WIDTH (LABEL_WIDTH),
        .DATA_WIDTH (BOX_WIDTH)
    ) u_box_table (
        .i_clk   (clk),
        .i_we    (w_write),
        .i_waddr (r_label),
        .i_wdata (w_new_box),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign w_old_xmin  = w_ram_rdata[box_xmin_lsb(COORD_WIDTH) +: COORD_WIDTH];
    assign w_old_xmax  = w_ram_rdata[box_xmax_lsb(COORD_WIDTH) +: COORD_WIDTH];
    assign w_old_ymin  = w_ram_rdata[box_ymin_lsb(COORD_WIDTH) +: COORD_WIDTH];
    assign w_old_ymax  = w_ram_rdata[BOX_YMAX_LSB +: COORD_WIDTH];
    assign w_was_valid = r_valid[r_label];

    // Merge the pixel into the stored box; an unseen label starts from a point box
    assign w_xmin    = (w_was_valid && (w_old_xmin < r_x)) ? w_old_xmin : r_x;
    assign w_xmax    = (w_was_valid && (w_old_xmax > r_x)) ? w_old_xmax : r_x;
    assign w_ymin    = (w_was_valid && (w_old_ymin < r_y)) ? w_old_ymin : r_y;
    assign w_ymax    = (w_was_valid && (w_old_ymax > r_y)) ? w_old_ymax : r_y;
    assign w_new_box = {w_xmin, w_xmax, w_ymin, w_ymax};

    // Background label and clear both suppress the table write
    assign w_write = (r_state == S_UPDATE) && (r_label != '0) && !clear;

    // Per-label valid flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (clear) begin
            r_valid <= '0;
        end else if (w_write) begin
            r_valid[r_label] <= 1'b1;
        end
    end

    // Distinct-label counter, bumped on first sight of a label
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num <= '0;
        end else if (clear) begin
            r_num <= '0;
        end else if (w_write && !w_was_valid && (r_num != NUM_MAX)) begin
            r_num <= r_num + 1'b1;
        end
    end

    // A lookup of the label being written this cycle must see the merged box, not the stale RAM word
    assign w_fwd = rd_en && w_write && (rd_label == r_label);

    // Lookup response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_fwd   <= 1'b0;
            r_fwd_box  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_hit   <= rd_en && !clear && (w_fwd || r_valid[rd_label]);
            r_rd_fwd   <= w_fwd;
            if (w_fwd) begin
                r_fwd_box <= w_new_box;
            end
        end
    end

    assign q_dequeue   = w_sample;
    assign rd_valid    = r_rd_valid;
    assign rd_hit      = r_rd_hit;
    assign rd_box      = r_rd_hit ? (r_rd_fwd ? r_fwd_box : w_ram_rdata) : '0;
    assign num_objects = r_num;
    assign busy        = (r_state == S_UPDATE);

endmodule

// File: tb/tb_bbox_accumulator.sv
// tb/tb_bbox_accumulator.sv - randomized and directed bench for bbox_accumulator
module tb_bbox_accumulator;

    localparam int LW = 8;
    localparam int CW = 10;
    localparam int EW = LW + 2 * CW;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            q_empty;
    logic [EW-1:0]   q_data = '0;
    logic            q_dequeue;
    logic            rd_en;
    logic [LW-1:0]   rd_label;
    logic            rd_valid;
    logic            rd_hit;
    logic [4*CW-1:0] rd_box;
    logic [LW:0]     num_objects;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    bbox_accumulator #(.LABEL_WIDTH(LW), .COORD_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .q_empty     (q_empty),
        .q_data      (q_data),
        .q_dequeue   (q_dequeue),
        .rd_en       (rd_en),
        .rd_label    (rd_label),
        .rd_valid    (rd_valid),
        .rd_hit      (rd_hit),
        .rd_box      (rd_box),
        .num_objects (num_objects),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Upstream queue: registered data output that follows the read pointer one cycle late
    logic [EW-1:0] qmem [0:1023];
    logic [9:0]    wr_ptr = '0;
    logic [9:0]    rd_ptr = '0;
    assign q_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (q_dequeue) begin
            rd_ptr <= rd_ptr + 10'd1;
            q_data <= qmem[rd_ptr + 10'd1];
        end else begin
            q_data <= qmem[rd_ptr];
        end
    end

    // Reference model: bounding boxes as plain per-label arrays
    bit          m_valid [0:255];
    int unsigned m_xmin [0:255], m_xmax [0:255], m_ymin [0:255], m_ymax [0:255];
    int          m_num;

    function automatic void m_reset();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_num = 0;
    endfunction

    function automatic void m_apply(input int l, input int unsigned x, input int unsigned y);
        if (l == 0) return;
        if (!m_valid[l]) begin
            m_valid[l] = 1'b1;
            m_xmin[l] = x; m_xmax[l] = x; m_ymin[l] = y; m_ymax[l] = y;
            if (m_num < 255) m_num++;
        end else begin
            if (x < m_xmin[l]) m_xmin[l] = x;
            if (x > m_xmax[l]) m_xmax[l] = x;
            if (y < m_ymin[l]) m_ymin[l] = y;
            if (y > m_ymax[l]) m_ymax[l] = y;
        end
    endfunction

    function automatic logic [4*CW-1:0] m_box(input int l);
        logic [CW-1:0] a, b, c, d;
        if (!m_valid[l]) return '0;
        a = CW'(m_xmin[l]); b = CW'(m_xmax[l]); c = CW'(m_ymin[l]); d = CW'(m_ymax[l]);
        return {a, b, c, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int l, input int unsigned x, input int unsigned y, input bit model);
        logic [LW-1:0] lb;
        logic [CW-1:0] xb, yb;
        lb = LW'(l); xb = CW'(x); yb = CW'(y);
        qmem[wr_ptr] = {lb, xb, yb};
        wr_ptr = wr_ptr + 10'd1;
        if (model) m_apply(l, x, y);
    endtask

    task automatic lookup(input int l, input string tag);
        @(negedge clk);
        rd_en    = 1'b1;
        rd_label = LW'(l);
        @(negedge clk);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_hit"}, rd_hit, m_valid[l]);
        check({tag, "_box"}, rd_box, m_box(l));
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((rd_ptr != wr_ptr || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 2000), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned rx, ry, r;
        int rl;
        reset = 1'b1; clear = 1'b0; rd_en = 1'b0; rd_label = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_dequeue", q_dequeue, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_hit", rd_hit, 1'b0);
        check("rst_rd_box", rd_box, '0);
        check("rst_num", num_objects, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single entry: one pop, point box
        push(3, 5, 7, 1);
        drain();
        lookup(3, "single");
        check("single_box_const", rd_box, {10'd5, 10'd5, 10'd7, 10'd7});
        check("single_num", num_objects, 9'd1);

        // Same label grows its box; unseen label misses
        push(3, 2, 9, 1);
        push(3, 8, 4, 1);
        drain();
        lookup(3, "grow");
        check("grow_box_const", rd_box, {10'd2, 10'd8, 10'd4, 10'd9});
        check("grow_num", num_objects, 9'd1);
        lookup(4, "miss");
        check("miss_box_const", rd_box, '0);

        // Four queued entries: pops on alternate cycles starting the cycle after q_empty falls
        push(3, 1, 1, 1);
        push(0, 3, 3, 1);
        push(3, 9, 0, 1);
        push(0, 7, 7, 1);
        #1;
        check("burst_deq_0", q_dequeue, 1'b0);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("burst_deq_%0d", i), q_dequeue, (i == 1 || i == 3 || i == 5 || i == 7));
        end
        drain();
        check("burst_num", num_objects, 9'd1);
        lookup(3, "burst");
        lookup(0, "bg");

        // Lookup during the UPDATE of a first pixel returns the forwarded box
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        push(3, 1023, 0, 1);
        @(negedge clk);
        check("fwd_deq", q_dequeue, 1'b1);
        @(negedge clk);
        check("fwd_busy", busy, 1'b1);
        rd_en = 1'b1; rd_label = 8'd3;
        @(negedge clk);
        rd_en = 1'b0;
        check("fwd_valid", rd_valid, 1'b1);
        check("fwd_hit", rd_hit, 1'b1);
        check("fwd_box", rd_box, {10'd1023, 10'd1023, 10'd0, 10'd0});
        drain();
        lookup(3, "fwd_after");

        // Held lookup blocks sampling until it drops
        rd_en = 1'b1; rd_label = 8'd3;
        push(6, 100, 200, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("hold_deq_%0d", i), q_dequeue, 1'b0);
        end
        rd_en = 1'b0;
        #1;
        check("hold_release_deq", q_dequeue, 1'b1);
        drain();
        lookup(6, "hold");
        check("hold_num", num_objects, 9'(m_num));

        // Async reset in the middle of an UPDATE
        push(9, 10, 20, 0);
        @(negedge clk);
        check("rstmid_deq", q_dequeue, 1'b1);
        @(negedge clk);
        check("rstmid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rstmid_deq_low", q_dequeue, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_num", num_objects, '0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        lookup(9, "rstmid_l9");
        lookup(3, "rstmid_l3");

        // Clear during an UPDATE discards the write
        push(2, 4, 4, 1);
        drain();
        check("clr_pre_num", num_objects, 9'd1);
        push(7, 1, 1, 0);
        @(negedge clk);
        check("clr_deq", q_dequeue, 1'b1);
        @(negedge clk);
        check("clr_busy_pre", busy, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", busy, 1'b0);
        check("clr_deq_low", q_dequeue, 1'b0);
        check("clr_num", num_objects, '0);
        m_reset();
        lookup(7, "clr_l7");
        lookup(2, "clr_l2");

        // Random entries against the model
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r  = $urandom_range(0, 9);
            rl = (r == 0) ? 255 : $urandom_range(0, 7);
            r  = $urandom_range(0, 9);
            rx = (r == 0) ? 1023 : (r == 1) ? 0 : $urandom_range(0, 1023);
            r  = $urandom_range(0, 9);
            ry = (r == 0) ? 1023 : (r == 1) ? 0 : $urandom_range(0, 1023);
            push(rl, rx, ry, 1);
        end
        drain();
        for (int l = 0; l < 8; l++) lookup(l, $sformatf("rand_l%0d", l));
        lookup(255, "rand_l255");
        check("rand_num", num_objects, 9'(m_num));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
